// File: rtl/goertzel_pkg.sv
// rtl/goertzel_pkg.sv - shared FSM encodings, Q2.14 constants and width defaults
package goertzel_pkg;

  localparam int DEF_NUM_BINS = 4;
  localparam int DEF_BIN_BITS = 2;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_ACC_W    = 16;

  // Q2.14: 2 integer bits (incl. sign), 14 fractional bits
  localparam int          Q_FRAC_BITS = 14;
  localparam logic [15:0] Q2_14_ONE   = 16'h4000;
  localparam logic [15:0] Q2_14_ZERO  = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

endpackage

// File: rtl/goertzel_bin_scheduler_if.sv
// rtl/goertzel_bin_scheduler_if.sv - control, loop-core and result signals of the bin scheduler
// BIN_MASK_EN adds the per-frame bin_mask input.
interface goertzel_bin_scheduler_if
  import goertzel_pkg::*;
#(
  parameter int NUM_BINS = DEF_NUM_BINS,
  parameter int BIN_BITS = DEF_BIN_BITS,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int ACC_W    = DEF_ACC_W
) ();

  logic                enable;
  logic                frame_rdy;
  logic                frame_bank;
  logic                cfg_wr_en;
  logic [BIN_BITS-1:0] cfg_wr_addr;
  logic [COEF_W-1:0]   cfg_wr_data;
  logic                ovr_clr;
  logic                core_start;
  logic [COEF_W-1:0]   core_coeff;
  logic                core_done;
  logic [ACC_W-1:0]    core_t1;
  logic [ACC_W-1:0]    core_t2;
  logic                rd_bank;
  logic                res_valid;
  logic                res_ready;
  logic [BIN_BITS-1:0] res_bin;
  logic [ACC_W-1:0]    res_t1;
  logic [ACC_W-1:0]    res_t2;
  logic                busy;
  logic                frame_done;
  logic                overrun;
`ifdef BIN_MASK_EN
  logic [NUM_BINS-1:0] bin_mask;
`endif

  modport master (
    input  enable, frame_rdy, frame_bank, cfg_wr_en, cfg_wr_addr, cfg_wr_data, ovr_clr,
    input  core_done, core_t1, core_t2, res_ready,
`ifdef BIN_MASK_EN
    input  bin_mask,
`endif
    output core_start, core_coeff, rd_bank, res_valid, res_bin, res_t1, res_t2,
    output busy, frame_done, overrun
  );

  modport slave (
    output enable, frame_rdy, frame_bank, cfg_wr_en, cfg_wr_addr, cfg_wr_data, ovr_clr,
    output core_done, core_t1, core_t2, res_ready,
`ifdef BIN_MASK_EN
    output bin_mask,
`endif
    input  core_start, core_coeff, rd_bank, res_valid, res_bin, res_t1, res_t2,
    input  busy, frame_done, overrun
  );

endinterface

// File: rtl/goertzel_coef_table.sv
// rtl/goertzel_coef_table.sv - NUM_BINS x COEF_W coefficient register file, sync write, async read
module goertzel_coef_table
  import goertzel_pkg::*;
#(
  parameter int NUM_BINS = DEF_NUM_BINS,
  parameter int BIN_BITS = DEF_BIN_BITS,
  parameter int COEF_W   = DEF_COEF_W
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                i_en,
  input  logic                i_wr_en,
  input  logic [BIN_BITS-1:0] i_wr_addr,
  input  logic [COEF_W-1:0]   i_wr_data,
  input  logic [BIN_BITS-1:0] i_rd_addr,
  output logic [COEF_W-1:0]   o_rd_data
);

  logic [COEF_W-1:0] r_mem [NUM_BINS];
  logic              w_addr_ok;

  // Indices past the last bin are silently dropped
  assign w_addr_ok = int'(i_wr_addr) < NUM_BINS;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) r_mem[i] <= '0;
    end else if (i_en && i_wr_en && w_addr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/goertzel_bin_scheduler.sv
// rtl/goertzel_bin_scheduler.sv - runs the shared Goertzel loop core over every bin of each filled bank
// BIN_MASK_EN: per-frame bin_mask selects which bins are evaluated.
module goertzel_bin_scheduler
  import goertzel_pkg::*;
#(
  parameter int NUM_BINS = DEF_NUM_BINS,
  parameter int BIN_BITS = DEF_BIN_BITS,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input logic                      sys_clk,
  input logic                      sys_rst_n,
  goertzel_bin_scheduler_if.master bus
);

  state_t              r_state, w_state_nxt;
  logic [BIN_BITS-1:0] r_bin;
  logic                r_core_start;
  logic [COEF_W-1:0]   r_core_coeff;
  logic                r_rd_bank;
  logic                r_res_valid;
  logic [BIN_BITS-1:0] r_res_bin;
  logic [ACC_W-1:0]    r_res_t1;
  logic [ACC_W-1:0]    r_res_t2;
  logic                r_frame_done;
  logic                r_overrun;

  logic [COEF_W-1:0]   w_coef;
  logic [NUM_BINS-1:0] w_mask_now;
  logic [NUM_BINS-1:0] w_mask_run;
  logic [BIN_BITS:0]   w_first;
  logic [BIN_BITS:0]   w_next;
  logic                w_start, w_load, w_capture, w_accept;

`ifdef BIN_MASK_EN
  logic [NUM_BINS-1:0] r_mask;
  assign w_mask_now = bus.bin_mask;
  assign w_mask_run = r_mask;
`else
  assign w_mask_now = '1;
  assign w_mask_run = '1;
`endif

  // Lowest enabled bin at or above start; MSB flags that one exists
  function automatic logic [BIN_BITS:0] find_from(input logic [NUM_BINS-1:0] m, input int start);
    find_from = '0;
    for (int i = NUM_BINS - 1; i >= 0; i--) begin
      if (i >= start && m[i]) find_from = {1'b1, BIN_BITS'(i)};
    end
  endfunction

  assign w_first = find_from(w_mask_now, 0);
  assign w_next  = find_from(w_mask_run, int'(r_bin) + 1);

  goertzel_coef_table #(
    .NUM_BINS (NUM_BINS),
    .BIN_BITS (BIN_BITS),
    .COEF_W   (COEF_W)
  ) u_coef_table (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_en      (bus.enable),
    .i_wr_en   (bus.cfg_wr_en),
    .i_wr_addr (bus.cfg_wr_addr),
    .i_wr_data (bus.cfg_wr_data),
    .i_rd_addr (r_bin),
    .o_rd_data (w_coef)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)      r_state <= ST_IDLE;
    else if (bus.enable) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.frame_rdy) begin
          w_start = 1'b1;
          if (w_first[BIN_BITS]) w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // done is ignored in the start cycle so a stale level cannot complete the new run
        if (!r_core_start && bus.core_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.res_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = w_next[BIN_BITS] ? ST_LOAD : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_bin        <= '0;
      r_core_start <= 1'b0;
      r_core_coeff <= '0;
      r_rd_bank    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_bin    <= '0;
      r_res_t1     <= '0;
      r_res_t2     <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef BIN_MASK_EN
      r_mask       <= '0;
`endif
    end else if (bus.enable) begin
      r_core_start <= w_load;
      r_frame_done <= 1'b0;
      if (bus.frame_rdy && r_state != ST_IDLE) r_overrun <= 1'b1;
      else if (bus.ovr_clr)                    r_overrun <= 1'b0;
      if (w_start) begin
        r_rd_bank    <= bus.frame_bank;
        r_bin        <= w_first[BIN_BITS-1:0];
        r_frame_done <= !w_first[BIN_BITS];
`ifdef BIN_MASK_EN
        r_mask       <= bus.bin_mask;
`endif
      end
      // 2*cos(w) by left shift; wraps for |cos| >= 1
      if (w_load) r_core_coeff <= {w_coef[COEF_W-2:0], 1'b0};
      if (w_capture) begin
        r_res_t1    <= bus.core_t1;
        r_res_t2    <= bus.core_t2;
        r_res_bin   <= r_bin;
        r_res_valid <= 1'b1;
      end
      if (w_accept) begin
        r_res_valid <= 1'b0;
        if (w_next[BIN_BITS]) r_bin        <= w_next[BIN_BITS-1:0];
        else                  r_frame_done <= 1'b1;
      end
    end
  end

  assign bus.core_start = r_core_start;
  assign bus.core_coeff = r_core_coeff;
  assign bus.rd_bank    = r_rd_bank;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_bin    = r_res_bin;
  assign bus.res_t1     = r_res_t1;
  assign bus.res_t2     = r_res_t2;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// tb/tb_goertzel_bin_scheduler.sv - directed table-driven bench for goertzel_bin_scheduler
module tb_goertzel_bin_scheduler;

  typedef struct {
    logic [15:0] cos_in;
    logic [15:0] exp_coeff;
    logic [15:0] t1;
    logic [15:0] t2;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  vec_t vec [4];

  goertzel_bin_scheduler_if #(.NUM_BINS(4), .BIN_BITS(2), .COEF_W(16), .ACC_W(16)) bus ();

  goertzel_bin_scheduler #(.NUM_BINS(4), .BIN_BITS(2), .COEF_W(16), .ACC_W(16)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic write_coef(input logic [1:0] addr, input logic [15:0] data);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = addr;
    bus.cfg_wr_data = data;
    tick();
    bus.cfg_wr_en   = 1'b0;
  endtask

  task automatic start_frame(input logic bank);
    bus.frame_rdy  = 1'b1;
    bus.frame_bank = bank;
    tick();
    bus.frame_rdy  = 1'b0;
    chk("rd_bank_latched", bus.rd_bank, bank);
    chk("busy_after_frame_rdy", bus.busy, 1);
  endtask

  // One bin: wait for start, optional stale done, optional enable gap, optional res_ready hold
  task automatic run_bin(input int i, input bit hold, input bit en_gap, input bit early_done);
    int cnt;
    cnt = 0;
    while (bus.core_start !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk($sformatf("core_start_seen_b%0d", i), bus.core_start, 1);
    chk($sformatf("core_coeff_b%0d", i), bus.core_coeff, vec[i].exp_coeff);
    if (early_done) begin
      bus.core_done = 1'b1;
      bus.core_t1   = 16'hDEAD;
    end
    tick();
    bus.core_done = 1'b0;
    chk("core_start_one_cycle", bus.core_start, 0);
    if (early_done) chk("done_ignored_during_start", bus.res_valid, 0);
    bus.core_t1   = vec[i].t1;
    bus.core_t2   = vec[i].t2;
    bus.res_ready = !hold;
    bus.core_done = 1'b1;
    if (en_gap) begin
      bus.enable = 1'b0;
      repeat (3) begin
        tick();
        chk("no_capture_while_disabled", bus.res_valid, 0);
      end
      bus.enable = 1'b1;
    end
    tick();
    bus.core_done = 1'b0;
    chk($sformatf("res_valid_b%0d", i), bus.res_valid, 1);
    chk($sformatf("res_bin_b%0d", i), bus.res_bin, i);
    chk($sformatf("res_t1_b%0d", i), bus.res_t1, vec[i].t1);
    chk($sformatf("res_t2_b%0d", i), bus.res_t2, vec[i].t2);
    if (hold) begin
      repeat (5) begin
        tick();
        chk("hold_res_valid", bus.res_valid, 1);
        chk("hold_res_t1_stable", bus.res_t1, vec[i].t1);
        chk("hold_no_next_start", bus.core_start, 0);
      end
      bus.res_ready = 1'b1;
    end
    tick();
    chk($sformatf("res_accepted_b%0d", i), bus.res_valid, 0);
  endtask

  task automatic end_frame();
    chk("frame_done_pulse", bus.frame_done, 1);
    chk("idle_after_frame", bus.busy, 0);
    tick();
    chk("frame_done_one_cycle", bus.frame_done, 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    vec[0] = '{16'h1413, 16'h2826, 16'h0100, 16'hFF00};
    vec[1] = '{16'h2D41, 16'h5A82, 16'h7FFF, 16'h8000};
    vec[2] = '{16'hE000, 16'hC000, 16'h1234, 16'hEDCB};
    vec[3] = '{16'h5000, 16'hA000, 16'h0001, 16'hFFFF};

    rst_n           = 1'b0;
    bus.enable      = 1'b1;
    bus.frame_rdy   = 1'b0;
    bus.frame_bank  = 1'b0;
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_wr_addr = '0;
    bus.cfg_wr_data = '0;
    bus.ovr_clr     = 1'b0;
    bus.core_done   = 1'b0;
    bus.core_t1     = '0;
    bus.core_t2     = '0;
    bus.res_ready   = 1'b1;
`ifdef BIN_MASK_EN
    bus.bin_mask    = 4'b1111;
`endif
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_core_coeff", bus.core_coeff, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) write_coef(2'(i), vec[i].cos_in);

    // Frame 1: bank 1, start latency, res_ready hold on bin 1
    start_frame(1'b1);
    chk("start_not_yet", bus.core_start, 0);
    tick();
    chk("start_two_cycles_after", bus.core_start, 1);
    for (int i = 0; i < 4; i++) run_bin(i, i == 1, 1'b0, 1'b0);
    end_frame();

    // Frame 2: overrun with coincident clear, mid-frame table write, stale done, enable gap
    start_frame(1'b0);
    bus.frame_rdy   = 1'b1;
    bus.frame_bank  = 1'b1;
    bus.ovr_clr     = 1'b1;
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = 2'd2;
    bus.cfg_wr_data = 16'h0800;
    tick();
    bus.frame_rdy   = 1'b0;
    bus.ovr_clr     = 1'b0;
    bus.cfg_wr_en   = 1'b0;
    vec[2].exp_coeff = 16'h1000;
    chk("overrun_set_wins", bus.overrun, 1);
    chk("dropped_frame_bank", bus.rd_bank, 0);
    for (int i = 0; i < 4; i++) run_bin(i, 1'b0, i == 1, i == 0);
    end_frame();
    chk("overrun_sticky", bus.overrun, 1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("overrun_cleared", bus.overrun, 0);

    // Frame 3: table write coincident with frame_rdy is seen by bin 0
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = 2'd0;
    bus.cfg_wr_data = 16'h1000;
    start_frame(1'b1);
    bus.cfg_wr_en   = 1'b0;
    vec[0].exp_coeff = 16'h2000;
    for (int i = 0; i < 4; i++) run_bin(i, 1'b0, 1'b0, 1'b0);
    end_frame();

`ifdef BIN_MASK_EN
    bus.bin_mask = 4'b1010;
    start_frame(1'b0);
    run_bin(1, 1'b0, 1'b0, 1'b0);
    run_bin(3, 1'b0, 1'b0, 1'b0);
    end_frame();
    bus.bin_mask  = 4'b0000;
    bus.frame_rdy = 1'b1;
    tick();
    bus.frame_rdy = 1'b0;
    chk("all_masked_frame_done", bus.frame_done, 1);
    chk("all_masked_idle", bus.busy, 0);
    chk("all_masked_no_start", bus.core_start, 0);
    tick();
    chk("all_masked_done_one_cycle", bus.frame_done, 0);
    chk("all_masked_no_result", bus.res_valid, 0);
    bus.bin_mask = 4'b1111;
`endif

    // Reset mid-frame aborts and clears the table
    start_frame(1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", bus.busy, 0);
    chk("abort_core_start", bus.core_start, 0);
    chk("abort_frame_done", bus.frame_done, 0);
    chk("abort_rd_bank", bus.rd_bank, 0);
    rst_n = 1'b1;
    tick();
    start_frame(1'b0);
    tick();
    chk("table_reset_start", bus.core_start, 1);
    chk("table_reset_coeff", bus.core_coeff, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
